ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM output register.
// Forwarding, ALU and branch logic are combinational; results appear one cycle later.
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        idex_valid,
  input  logic [6:0]  idex_opcode,
  input  logic [2:0]  idex_funct3,
  input  logic [6:0]  idex_funct7,
  input  logic [4:0]  idex_rs1,
  input  logic [4:0]  idex_rs2,
  input  logic [4:0]  idex_rd,
  input  logic [31:0] idex_a,
  input  logic [31:0] idex_b,
  input  logic [31:0] idex_imm,
  input  logic [31:0] idex_pc,
  input  logic        exmem_valid,
  input  logic [6:0]  exmem_opcode,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_valid,
  input  logic [6:0]  memwb_opcode,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_value,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        takebranch,
  output logic [31:0] target_addr,
  output logic        ex_valid,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_result,
  output logic [31:0] ex_store_data
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic        w_rs1Used, w_rs2Used;
  logic        w_exWrites, w_wbWrites;
  logic [31:0] w_opA, w_opB, w_aluB, w_aluOut, w_result;
  logic [31:0] w_pcPlusImm, w_jalrSum;
  logic [4:0]  w_shamt;
  logic        w_branchTaken;
  logic        w_unusedFunct7;

  logic        r_exValid;
  logic [6:0]  r_exOpcode;
  logic [2:0]  r_exFunct3;
  logic [4:0]  r_exRd;
  logic [31:0] r_exResult, r_exStoreData;

  function automatic logic writesRd(input logic valid, input logic [6:0] opc, input logic [4:0] rd);
    logic opWrites;
    opWrites = (opc == OP_OP) || (opc == OP_IMM) || (opc == OP_LOAD) || (opc == OP_JAL) ||
               (opc == OP_JALR) || (opc == OP_LUI) || (opc == OP_AUIPC);
    return valid && (rd != 5'd0) && opWrites;
  endfunction

  assign w_rs1Used = (idex_opcode == OP_OP) || (idex_opcode == OP_IMM) || (idex_opcode == OP_LOAD) ||
                     (idex_opcode == OP_STORE) || (idex_opcode == OP_BRANCH) || (idex_opcode == OP_JALR);
  assign w_rs2Used = (idex_opcode == OP_OP) || (idex_opcode == OP_STORE) || (idex_opcode == OP_BRANCH);

  assign w_exWrites = writesRd(exmem_valid, exmem_opcode, exmem_rd) && (exmem_opcode != OP_LOAD);
  assign w_wbWrites = writesRd(memwb_valid, memwb_opcode, memwb_rd);

  // A load still in MEM has no data yet, so only the WB path may supply it
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (w_rs1Used && w_exWrites && (exmem_rd == idex_rs1))      fwd_a_sel = 2'd1;
    else if (w_rs1Used && w_wbWrites && (memwb_rd == idex_rs1)) fwd_a_sel = 2'd2;
    if (w_rs2Used && w_exWrites && (exmem_rd == idex_rs2))      fwd_b_sel = 2'd1;
    else if (w_rs2Used && w_wbWrites && (memwb_rd == idex_rs2)) fwd_b_sel = 2'd2;
  end

  always_comb begin
    case (fwd_a_sel)
      2'd1:    w_opA = exmem_result;
      2'd2:    w_opA = memwb_value;
      default: w_opA = idex_a;
    endcase
    case (fwd_b_sel)
      2'd1:    w_opB = exmem_result;
      2'd2:    w_opB = memwb_value;
      default: w_opB = idex_b;
    endcase
  end

  assign w_aluB         = (idex_opcode == OP_OP) ? w_opB : idex_imm;
  assign w_shamt        = w_aluB[4:0];
  assign w_unusedFunct7 = ^{idex_funct7[6], idex_funct7[4:0]};

  always_comb begin
    w_aluOut = '0;
    case (idex_funct3)
      3'b000:  w_aluOut = ((idex_opcode == OP_OP) && idex_funct7[5]) ? (w_opA - w_aluB) : (w_opA + w_aluB);
      3'b001:  w_aluOut = w_opA << w_shamt;
      3'b010:  w_aluOut = {31'd0, $signed(w_opA) < $signed(w_aluB)};
      3'b011:  w_aluOut = {31'd0, w_opA < w_aluB};
      3'b100:  w_aluOut = w_opA ^ w_aluB;
      3'b101:  w_aluOut = idex_funct7[5] ? 32'($signed(w_opA) >>> w_shamt) : (w_opA >> w_shamt);
      3'b110:  w_aluOut = w_opA | w_aluB;
      default: w_aluOut = w_opA & w_aluB;
    endcase
  end

  assign w_pcPlusImm = idex_pc + idex_imm;
  assign w_jalrSum   = w_opA + idex_imm;

  always_comb begin
    w_result = '0;
    case (idex_opcode)
      OP_OP, OP_IMM:     w_result = w_aluOut;
      OP_LOAD, OP_STORE: w_result = w_opA + idex_imm;
      OP_LUI:            w_result = idex_imm;
      OP_AUIPC:          w_result = w_pcPlusImm;
      OP_JAL, OP_JALR:   w_result = idex_pc + 32'd4;
      default:           w_result = '0;
    endcase
  end

  always_comb begin
    w_branchTaken = 1'b0;
    case (idex_funct3)
      3'b000:  w_branchTaken = (w_opA == w_opB);
      3'b001:  w_branchTaken = (w_opA != w_opB);
      3'b100:  w_branchTaken = ($signed(w_opA) < $signed(w_opB));
      3'b101:  w_branchTaken = ($signed(w_opA) >= $signed(w_opB));
      3'b110:  w_branchTaken = (w_opA < w_opB);
      3'b111:  w_branchTaken = (w_opA >= w_opB);
      default: w_branchTaken = 1'b0;
    endcase
  end

  always_comb begin
    target_addr = '0;
    if ((idex_opcode == OP_BRANCH) || (idex_opcode == OP_JAL)) target_addr = w_pcPlusImm;
    else if (idex_opcode == OP_JALR)                          target_addr = w_jalrSum & ~32'd1;
  end

  assign takebranch = idex_valid && !stall &&
                      (((idex_opcode == OP_BRANCH) && w_branchTaken) ||
                       (idex_opcode == OP_JAL) || (idex_opcode == OP_JALR));

  // Reset wins over stall so an in-flight instruction is always discarded
  always_ff @(posedge clock) begin
    if (reset) begin
      r_exValid     <= 1'b0;
      r_exOpcode    <= '0;
      r_exFunct3    <= '0;
      r_exRd        <= '0;
      r_exResult    <= '0;
      r_exStoreData <= '0;
    end else if (!stall) begin
      r_exValid     <= idex_valid;
      r_exOpcode    <= idex_opcode;
      r_exFunct3    <= idex_funct3;
      r_exRd        <= idex_valid ? idex_rd : 5'd0;
      r_exResult    <= w_result;
      r_exStoreData <= w_opB;
    end
  end

  assign ex_valid      = r_exValid;
  assign ex_opcode     = r_exOpcode;
  assign ex_funct3     = r_exFunct3;
  assign ex_rd         = r_exRd;
  assign ex_result     = r_exResult;
  assign ex_store_data = r_exStoreData;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset, stall;
  logic        idex_valid;
  logic [6:0]  idex_opcode, idex_funct7;
  logic [2:0]  idex_funct3;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc;
  logic        exmem_valid, memwb_valid;
  logic [6:0]  exmem_opcode, memwb_opcode;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_value;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        takebranch;
  logic [31:0] target_addr;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result, ex_store_data;

  int numChecks = 0;
  int numFails  = 0;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  ex_stage dut (
    .clock(clock), .reset(reset), .stall(stall),
    .idex_valid(idex_valid), .idex_opcode(idex_opcode), .idex_funct3(idex_funct3),
    .idex_funct7(idex_funct7), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm), .idex_pc(idex_pc),
    .exmem_valid(exmem_valid), .exmem_opcode(exmem_opcode), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_valid(memwb_valid), .memwb_opcode(memwb_opcode),
    .memwb_rd(memwb_rd), .memwb_value(memwb_value), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .takebranch(takebranch), .target_addr(target_addr),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_store_data(ex_store_data)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    stall = 0; idex_valid = 0; idex_opcode = 0; idex_funct3 = 0; idex_funct7 = 0;
    idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_a = 0; idex_b = 0; idex_imm = 0; idex_pc = 0;
    exmem_valid = 0; exmem_opcode = 0; exmem_rd = 0; exmem_result = 0;
    memwb_valid = 0; memwb_opcode = 0; memwb_rd = 0; memwb_value = 0;
  endtask

  // Drives one valid ID/EX instruction and lets combinational outputs settle
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc);
    idex_valid = 1; idex_opcode = opc; idex_funct3 = f3; idex_funct7 = f7;
    idex_rs1 = rs1; idex_rs2 = rs2; idex_rd = rd;
    idex_a = a; idex_b = b; idex_imm = imm; idex_pc = pc;
    #1;
  endtask

  initial begin
    reset = 1;
    clearInputs();
    tick();
    tick();
    checkOutput("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset ex_result", ex_result, 32'd0);
    checkOutput("reset ex_rd", {27'd0, ex_rd}, 32'd0);
    checkOutput("reset ex_store_data", ex_store_data, 32'd0);
    reset = 0;

    applyStimulus(OP_OP, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0);
    checkOutput("add fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    tick();
    checkOutput("add result", ex_result, 32'd12);
    checkOutput("add rd", {27'd0, ex_rd}, 32'd3);
    checkOutput("add valid", {31'd0, ex_valid}, 32'd1);

    applyStimulus(OP_OP, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0);
    tick();
    checkOutput("sub result", ex_result, 32'hFFFF_FFFE);

    applyStimulus(OP_OP, 3'b101, 7'h20, 5'd1, 5'd2, 5'd4, 32'h8000_0000, 32'h0000_0024, 32'd0, 32'd0);
    tick();
    checkOutput("sra result", ex_result, 32'hF800_0000);
    applyStimulus(OP_OP, 3'b101, 7'h00, 5'd1, 5'd2, 5'd4, 32'h8000_0000, 32'h0000_0024, 32'd0, 32'd0);
    tick();
    checkOutput("srl result", ex_result, 32'h0800_0000);

    applyStimulus(OP_IMM, 3'b011, 7'h00, 5'd1, 5'd0, 5'd6, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0);
    tick();
    checkOutput("sltiu result", ex_result, 32'd1);
    applyStimulus(OP_IMM, 3'b010, 7'h00, 5'd1, 5'd0, 5'd6, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0);
    tick();
    checkOutput("slti result", ex_result, 32'd0);

    exmem_valid = 1; exmem_opcode = OP_OP;   exmem_rd = 5'd1; exmem_result = 32'd100;
    memwb_valid = 1; memwb_opcode = OP_LOAD; memwb_rd = 5'd1; memwb_value  = 32'd200;
    applyStimulus(OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd8, 32'd0, 32'd0, 32'd1, 32'd0);
    checkOutput("mem fwd sel", {30'd0, fwd_a_sel}, 32'd1);
    tick();
    checkOutput("mem fwd result", ex_result, 32'd101);
    exmem_valid = 0;
    #1;
    checkOutput("wb fwd sel", {30'd0, fwd_a_sel}, 32'd2);
    tick();
    checkOutput("wb fwd result", ex_result, 32'd201);

    clearInputs();
    exmem_valid = 1; exmem_opcode = OP_LOAD; exmem_rd = 5'd2; exmem_result = 32'd55;
    applyStimulus(OP_OP, 3'b000, 7'h00, 5'd0, 5'd2, 5'd9, 32'd0, 32'd3, 32'd0, 32'd0);
    checkOutput("load in mem no fwd", {30'd0, fwd_b_sel}, 32'd0);
    exmem_opcode = OP_OP; exmem_rd = 5'd0;
    #1;
    checkOutput("rd0 no fwd a", {30'd0, fwd_a_sel}, 32'd0);

    clearInputs();
    memwb_valid = 1; memwb_opcode = OP_OP; memwb_rd = 5'd5; memwb_value = 32'h0000_DEAD;
    applyStimulus(OP_STORE, 3'b010, 7'h00, 5'd0, 5'd5, 5'd0, 32'h1000, 32'd0, 32'd8, 32'd0);
    checkOutput("store fwd_b", {30'd0, fwd_b_sel}, 32'd2);
    tick();
    checkOutput("store addr", ex_result, 32'h1008);
    checkOutput("store data", ex_store_data, 32'h0000_DEAD);

    clearInputs();
    applyStimulus(OP_BRANCH, 3'b100, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100);
    checkOutput("blt taken", {31'd0, takebranch}, 32'd1);
    checkOutput("blt target", target_addr, 32'h0000_00F8);
    applyStimulus(OP_BRANCH, 3'b110, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100);
    checkOutput("bltu not taken", {31'd0, takebranch}, 32'd0);
    applyStimulus(OP_BRANCH, 3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'd4, 32'd4, 32'd16, 32'h100);
    checkOutput("bad funct3 not taken", {31'd0, takebranch}, 32'd0);

    applyStimulus(OP_LUI, 3'b000, 7'h00, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'h1234_5000, 32'd0);
    tick();
    checkOutput("lui result", ex_result, 32'h1234_5000);
    applyStimulus(OP_AUIPC, 3'b000, 7'h00, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'h1000, 32'h100);
    tick();
    checkOutput("auipc result", ex_result, 32'h1100);

    applyStimulus(OP_JAL, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h10, 32'h200);
    checkOutput("jal taken", {31'd0, takebranch}, 32'd1);
    checkOutput("jal target", target_addr, 32'h210);
    tick();
    checkOutput("jal link", ex_result, 32'h204);

    applyStimulus(OP_JALR, 3'b000, 7'h00, 5'd1, 5'd0, 5'd1, 32'h201, 32'd0, 32'd4, 32'h40);
    checkOutput("jalr taken", {31'd0, takebranch}, 32'd1);
    checkOutput("jalr target", target_addr, 32'h204);
    tick();
    checkOutput("jalr link", ex_result, 32'h44);

    stall = 1;
    applyStimulus(OP_JALR, 3'b000, 7'h00, 5'd1, 5'd0, 5'd7, 32'h201, 32'd0, 32'd4, 32'h80);
    checkOutput("stall no redirect", {31'd0, takebranch}, 32'd0);
    tick();
    checkOutput("stall hold result", ex_result, 32'h44);
    checkOutput("stall hold rd", {27'd0, ex_rd}, 32'd1);
    stall = 0;

    applyStimulus(OP_JAL, 3'b000, 7'h00, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h10, 32'h300);
    idex_valid = 0;
    #1;
    checkOutput("invalid no redirect", {31'd0, takebranch}, 32'd0);
    tick();
    checkOutput("invalid ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("invalid ex_rd", {27'd0, ex_rd}, 32'd0);

    applyStimulus(OP_OP, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0);
    tick();
    checkOutput("pre-reset valid", {31'd0, ex_valid}, 32'd1);
    stall = 1;
    reset = 1;
    tick();
    checkOutput("reset+stall valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset+stall result", ex_result, 32'd0);
    checkOutput("reset+stall rd", {27'd0, ex_rd}, 32'd0);
    checkOutput("reset+stall opcode", {25'd0, ex_opcode}, 32'd0);
    reset = 0;
    stall = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
